pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/irq_edge_sync.sv | 39 +++
 rtl/pc_fetch_unit.sv | 96 +++++++++
 tb/tb_pc_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch unit: reset/interrupt/exception
// vectors, the USER/KERNEL mode encoding and the branch-target helper.
package fetch_pkg;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

  // Mode encoding matches pc[31] so the state register mirrors the kernel bit.
  typedef enum logic {
    USER   = 1'b0,
    KERNEL = 1'b1
  } mode_e;

  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic [15:0] imm16);
    return base + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Rising-edge detector for the timer interrupt line. Define IRQ_SYNC_EN to
// add a two-flop synchroniser in front of the edge register.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

`ifdef IRQ_SYNC_EN
  logic sync1, sync2, prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
`else
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input before any of them update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= irq;
  end

  assign rise = irq & ~prev;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection with USER/KERNEL mode, timer interrupt
// and undefined-instruction vectoring. IRQ_SYNC_EN adds an irq synchroniser.
module pc_fetch_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] target26,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic        flush,
  output logic        kernel
);

  logic [31:0] pc_q, pc_d;
  mode_e       state_q, state_d;
  logic        irq_pend_q;
  logic        irq_rise;
  logic        irq_take;

  irq_edge_sync u_irq_edge_sync (
    .clk   (clk),
    .reset (reset),
    .irq   (irq),
    .rise  (irq_rise)
  );

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign kernel   = pc_q[31];

  assign irq_take = irq_pend_q & (state_q == USER) & ~stall & ~exc;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    epc     = pc_q;
    epc_we  = 1'b0;
    flush   = 1'b0;
    if (!stall) begin
      if (exc) begin
        pc_d    = EXC_VEC;
        state_d = KERNEL;
        epc     = pc_plus4;
        epc_we  = 1'b1;
        flush   = 1'b1;
      end else if (irq_take) begin
        // The interrupted instruction is squashed and re-executes on return.
        pc_d    = IRQ_VEC;
        state_d = KERNEL;
        epc     = pc_q;
        epc_we  = 1'b1;
        flush   = 1'b1;
      end else if (jr) begin
        if (state_q == USER) begin
          pc_d = {1'b0, jr_addr[30:0]};
        end else begin
          pc_d    = jr_addr;
          state_d = jr_addr[31] ? KERNEL : USER;
        end
      end else if (jump) begin
        pc_d = {pc_plus4[31:28], target26, 2'b00};
      end else if (branch) begin
        pc_d = branch_target(pc_plus4, imm16);
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_VEC;
      state_q    <= KERNEL;
      irq_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      // A new edge arriving in the same cycle as a take stays pending.
      irq_pend_q <= irq_rise | (irq_pend_q & ~irq_take);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random
// control traffic, all compared against a cycle-level reference model.
module tb_pc_fetch_unit;

`ifdef IRQ_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, jump, jr, irq, exc;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] jr_addr;
  logic [31:0] pc, pc_plus4, epc;
  logic        epc_we, flush, kernel;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_kern;
  bit          m_pend;
  bit          hist[$];

  pc_fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .branch   (branch),
    .imm16    (imm16),
    .jump     (jump),
    .target26 (target26),
    .jr       (jr),
    .jr_addr  (jr_addr),
    .irq      (irq),
    .exc      (exc),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .epc      (epc),
    .epc_we   (epc_we),
    .flush    (flush),
    .kernel   (kernel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit irq_at(input int k);
    return (k >= 0 && k < hist.size()) ? hist[k] : 1'b0;
  endfunction

  task automatic model_reset();
    m_pc   = 32'h8000_0000;
    m_kern = 1'b1;
    m_pend = 1'b0;
    hist.delete();
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit          rise, take;
    int          n;
    logic [31:0] p4;
    hist.push_back(irq);
    n    = hist.size() - 1;
    rise = irq_at(n - IRQ_LAT) && !irq_at(n - IRQ_LAT - 1);
    take = m_pend && !m_kern && !stall && !exc;
    p4   = m_pc + 32'd4;
    if (!stall) begin
      if (exc) begin
        m_pc = 32'h8000_0008; m_kern = 1'b1;
      end else if (take) begin
        m_pc = 32'h8000_0004; m_kern = 1'b1;
      end else if (jr) begin
        if (!m_kern) m_pc = jr_addr & 32'h7FFF_FFFF;
        else begin
          m_pc = jr_addr; m_kern = jr_addr[31];
        end
      end else if (jump) begin
        m_pc = {p4[31:28], target26, 2'b00};
      end else if (branch) begin
        m_pc = p4 + 32'(signed'(imm16)) * 32'd4;
      end else begin
        m_pc = p4;
      end
    end
    m_pend = rise || (m_pend && !take);
  endtask

  // Check combinational outputs against the model, then clock once.
  task automatic tick();
    bit take, we;
    #1;
    take = m_pend && !m_kern && !stall && !exc;
    we   = !stall && (exc || take);
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("kernel", {31'b0, kernel}, {31'b0, m_pc[31]});
    check("epc_we", {31'b0, epc_we}, {31'b0, we});
    check("flush", {31'b0, flush}, {31'b0, we});
    if (we) check("epc", epc, exc ? m_pc + 32'd4 : m_pc);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clr();
    stall = 0; branch = 0; jump = 0; jr = 0; exc = 0;
    imm16 = '0; target26 = '0; jr_addr = '0;
  endtask

  task automatic make_irq_edge();
    irq = 1'b0;
    repeat (4) tick();
    irq = 1'b1;
    repeat (IRQ_LAT + 3) tick();
  endtask

  initial begin
    bit seen;
    clr();
    irq   = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_pc", pc, 32'h8000_0000);
    check("reset_kernel", {31'b0, kernel}, 32'd1);
    check("reset_flush", {31'b0, flush}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Free-running sequence out of reset
    check("seq0", pc, 32'h8000_0000);
    tick();
    check("seq1", pc, 32'h8000_0004);
    tick();
    check("seq2", pc, 32'h8000_0008);
    check("seq2_kernel", {31'b0, kernel}, 32'd1);

    // Kernel jr to user, then branch and jump
    jr = 1; jr_addr = 32'h0000_0040; tick(); clr();
    check("jr_user_pc", pc, 32'h0000_0040);
    check("jr_user_kernel", {31'b0, kernel}, 32'd0);
    branch = 1; imm16 = 16'hFFFD; tick(); clr();
    check("branch_back", pc, 32'h0000_0038);
    jump = 1; target26 = 26'h000004B; tick(); clr();
    check("jump_tgt", pc, 32'h0000_012C);

    // jr in USER cannot enter kernel space
    jr = 1; jr_addr = 32'h8000_0020; tick(); clr();
    check("user_jr_pc", pc, 32'h0000_0020);
    check("user_jr_kernel", {31'b0, kernel}, 32'd0);

    // Interrupt taken in USER while spinning on a branch-to-self at 0x80
    jump = 1; target26 = 26'h0000020; tick(); clr();
    check("spin_pc", pc, 32'h0000_0080);
    irq = 1; branch = 1; imm16 = 16'hFFFF;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      #1;
      if (flush === 1'b1) begin
        seen = 1;
        check("irq_epc", epc, 32'h0000_0080);
        check("irq_epc_we", {31'b0, epc_we}, 32'd1);
      end
      tick();
    end
    check("irq_taken_in_budget", {31'b0, seen}, 32'd1);
    clr();
    check("irq_vec", pc, 32'h8000_0004);
    check("irq_vec_kernel", {31'b0, kernel}, 32'd1);

    // Edge in KERNEL stays pending until return to USER
    make_irq_edge();
    jr = 1; jr_addr = 32'h0000_0080; tick(); clr();
    check("ret_pc", pc, 32'h0000_0080);
    check("ret_kernel", {31'b0, kernel}, 32'd0);
    #1;
    check("ret_flush", {31'b0, flush}, 32'd1);
    check("ret_epc", epc, 32'h0000_0080);
    tick();
    check("ret_vec", pc, 32'h8000_0004);

    // Exception beats a pending interrupt, which is retained
    make_irq_edge();
    jr = 1; jr_addr = 32'h0000_0010; tick(); clr();
    exc = 1;
    #1;
    check("exc_epc", epc, 32'h0000_0014);
    check("exc_we", {31'b0, epc_we}, 32'd1);
    tick();
    check("exc_vec", pc, 32'h8000_0008);
    stall = 1;
    #1;
    check("stall_exc_we", {31'b0, epc_we}, 32'd0);
    check("stall_exc_flush", {31'b0, flush}, 32'd0);
    tick(); clr();
    check("stall_hold", pc, 32'h8000_0008);
    jr = 1; jr_addr = 32'h0000_0010; tick(); clr();
    #1;
    check("pend_kept_flush", {31'b0, flush}, 32'd1);
    check("pend_kept_epc", epc, 32'h0000_0010);
    tick();
    check("pend_kept_vec", pc, 32'h8000_0004);

    // Mid-operation reset discards a pending interrupt
    make_irq_edge();
    irq = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_pc", pc, 32'h8000_0000);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    jr = 1; jr_addr = 32'h0000_0040; tick(); clr();
    branch = 1; imm16 = 16'hFFFF;
    repeat (IRQ_LAT + 4) tick();
    clr();
    #1;
    check("midrst_no_irq", pc, 32'h0000_0040);

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      stall  = ($urandom_range(0, 9) == 0);
      exc    = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) irq = ~irq;
      jr     = ($urandom_range(0, 9) == 0);
      jr_addr = {1'($urandom_range(0, 1)), 23'b0, 6'($urandom_range(0, 63)), 2'b00};
      jump   = ($urandom_range(0, 6) == 0);
      target26 = 26'($urandom_range(0, 255));
      branch = ($urandom_range(0, 4) == 0);
      imm16  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
